// File: rtl/debug_frame_pkg.sv
// debug_frame_pkg: shared constants, state encoding and CRC16-CCITT byte step for the debug frame parser
package debug_frame_pkg;
  localparam logic [7:0] SYNC0_DEF = 8'h5A;
  localparam logic [7:0] SYNC1_DEF = 8'hA5;
  localparam logic [2:0] ERR_LEN = 3'd1;
  localparam logic [2:0] ERR_CRC = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  typedef enum logic [2:0] {
    S_SYNC0, S_SYNC1, S_CMD, S_LEN, S_DATA, S_CRC_HI, S_CRC_LO, S_HOLD
  } state_e;
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/debug_crc16_ccitt.sv
// debug_crc16_ccitt: byte-serial CRC16-CCITT; init restarts from CRC_INIT and may coincide with en
module debug_crc16_ccitt
  import debug_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  logic [15:0] crc_q, crc_d, base;
  always_comb begin
    base  = init ? CRC_INIT : crc_q;
    crc_d = en ? crc16_byte(base, data) : base;
  end
  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else crc_q <= crc_d;
  end
  assign crc = crc_q;
endmodule

// File: rtl/debug_frame_parser.sv
// debug_frame_parser: hunts sync, checks CRC16 and holds one validated command frame
// for the command decoder under a valid/ack handshake; malformed frames pulse frame_error.
module debug_frame_parser
  import debug_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC0          = SYNC0_DEF,
  parameter logic [7:0] SYNC1          = SYNC1_DEF,
  localparam int        PW             = $clog2(MAX_PAYLOAD),
  localparam int        LW             = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  input  logic          frame_ack,
  input  logic [PW-1:0] payload_raddr,
  output logic [7:0]    payload_rdata,
  output logic          frame_valid,
  output logic [7:0]    frame_cmd,
  output logic [LW-1:0] frame_len,
  output logic          frame_error,
  output logic [2:0]    error_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] MAX8 = 8'(MAX_PAYLOAD);
  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [7:0]    cmd_q, cmd_d, crc_hi_q, crc_hi_d, rdata_q;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d, wr_en, crc_init, crc_en;
  logic [2:0]    code_q, code_d;
  logic [15:0]   crc;
  logic [7:0]    mem_q [MAX_PAYLOAD];
  debug_crc16_ccitt u_crc (
    .clk  (clk),
    .rst  (sync_reset),
    .init (crc_init),
    .en   (crc_en),
    .data (rx_data),
    .crc  (crc)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    crc_hi_d = crc_hi_q;
    err_d    = 1'b0;
    code_d   = code_q;
    wr_en    = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    if (rx_done) cnt_d = '0;
    // an ack releases the frame even if a byte lands in the same cycle; that byte starts a new hunt
    if (state_q == S_HOLD && frame_ack) state_d = (rx_done && rx_data == SYNC0) ? S_SYNC1 : S_SYNC0;
    else if (rx_done) begin
      case (state_q)
        S_SYNC0: state_d = (rx_data == SYNC0) ? S_SYNC1 : S_SYNC0;
        S_SYNC1: state_d = (rx_data == SYNC1) ? S_CMD : (rx_data == SYNC0) ? S_SYNC1 : S_SYNC0;
        S_CMD: begin
          cmd_d    = rx_data;
          crc_init = 1'b1;
          crc_en   = 1'b1;
          state_d  = S_LEN;
        end
        S_LEN: begin
          crc_en = 1'b1;
          idx_d  = '0;
          if (rx_data > MAX8) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = S_SYNC0;
          end else begin
            len_d   = LW'(rx_data);
            state_d = (rx_data == 8'd0) ? S_CRC_HI : S_DATA;
          end
        end
        S_DATA: begin
          wr_en   = 1'b1;
          crc_en  = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = (LW'(idx_q) + LW'(1) == len_q) ? S_CRC_HI : S_DATA;
        end
        S_CRC_HI: begin
          crc_hi_d = rx_data;
          state_d  = S_CRC_LO;
        end
        S_CRC_LO: begin
          err_d   = ({crc_hi_q, rx_data} != crc);
          code_d  = err_d ? ERR_CRC : code_q;
          state_d = err_d ? S_SYNC0 : S_HOLD;
        end
        default: begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
      endcase
    end else if (state_q != S_SYNC0 && state_q != S_HOLD) begin
      if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = S_SYNC0;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q  <= S_SYNC0;
      cnt_q    <= '0;
      idx_q    <= '0;
      cmd_q    <= '0;
      len_q    <= '0;
      crc_hi_q <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      crc_hi_q <= crc_hi_d;
      err_q    <= err_d;
      code_q   <= code_d;
      rdata_q  <= mem_q[payload_raddr];
      if (wr_en) mem_q[idx_q] <= rx_data;
    end
  end
  assign payload_rdata = rdata_q;
  assign frame_valid   = (state_q == S_HOLD);
  assign frame_cmd     = cmd_q;
  assign frame_len     = len_q;
  assign frame_error   = err_q;
  assign error_code    = code_q;
endmodule
